// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the memory access stage.
package mem_access_stage_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } mem_size_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

    localparam logic [1:0] LANE_OFF0 = 2'd0;
    localparam logic [1:0] LANE_OFF1 = 2'd1;
    localparam logic [1:0] LANE_OFF2 = 2'd2;
    localparam logic [1:0] LANE_OFF3 = 2'd3;

endpackage

// File: rtl/mem_access_stage_lane_align.sv
// Little-endian lane alignment: byte enables, store replication, load
// extraction/extension and the misalignment flag.
module mem_lane_align
    import mem_access_stage_pkg::*;
(
    input  logic [1:0]  off,
    input  mem_size_t   size,
    input  logic        load_signed,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [31:0] shifted;

    always_comb begin
        byte_en    = 4'b0000;
        wdata      = 32'h0;
        load_data  = 32'h0;
        misaligned = 1'b0;
        shifted    = rdata >> {off, 3'b000};
        case (size)
            SZ_BYTE: begin
                byte_en   = 4'b0001 << off;
                wdata     = {4{store_data[7:0]}};
                load_data = {{24{load_signed & shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                byte_en    = 4'b0011 << off;
                wdata      = {2{store_data[15:0]}};
                load_data  = {{16{load_signed & shifted[15]}}, shifted[15:0]};
                misaligned = (off == LANE_OFF1) || (off == LANE_OFF3);
            end
            SZ_WORD: begin
                byte_en    = 4'b1111;
                wdata      = store_data;
                load_data  = shifted;
                misaligned = (off != LANE_OFF0);
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline memory stage: req/ack data-memory port with wait states and upstream stall.
// Optional watchdog abort of a stuck access when MEM_TIMEOUT_EN is defined.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        MemRead_In,
    input  logic        MemWrite_In,
    input  logic [1:0]  MemSize_In,
    input  logic        LoadSigned_In,
    input  logic        RegWrite_In,
    input  logic [4:0]  RegDest_In,
    input  logic [31:0] ALUResult_In,
    input  logic [31:0] StoreData_In,
    input  logic        DMemAck,
    input  logic [31:0] DMemRData,
    output logic        DMemReq,
    output logic        DMemWe,
    output logic [31:0] DMemAddr,
    output logic [3:0]  DMemByteEn,
    output logic [31:0] DMemWData,
    output logic        Stall,
    output logic [31:0] ALUResult_Out,
    output logic [31:0] ReadData_Out,
    output logic [4:0]  RegDest_Out,
    output logic        RegWrite_Out,
    output logic        MemToReg_Out,
    output logic        AddrError,
    output logic        BusError
);

    mem_state_t  state_q, state_d;
    logic [31:0] addr_q, sdata_q;
    mem_size_t   size_q;
    logic        signed_q, regwrite_q, we_q;
    logic [4:0]  dest_q;

    logic        busy, mem_op, start, timeout;
    logic [3:0]  byte_en;
    logic [31:0] wdata, load_data;
    logic        misaligned;

    assign busy   = (state_q == BUSY);
    assign mem_op = MemRead_In | MemWrite_In;

    // While idle the aligner judges the incoming op; while busy it serves the latched one.
    mem_lane_align u_align (
        .off         (busy ? addr_q[1:0] : ALUResult_In[1:0]),
        .size        (busy ? size_q : mem_size_t'(MemSize_In)),
        .load_signed (busy ? signed_q : LoadSigned_In),
        .store_data  (busy ? sdata_q : StoreData_In),
        .rdata       (DMemRData),
        .byte_en     (byte_en),
        .wdata       (wdata),
        .load_data   (load_data),
        .misaligned  (misaligned)
    );

    assign start = ~busy & mem_op & ~misaligned;

`ifdef MEM_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q;

    assign timeout = busy & ~DMemAck & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
        end else if (start) begin
            cnt_q <= '0;
        end else if (busy && !DMemAck) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{TIMEOUT_CYCLES, CNT_W};
    assign timeout    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = BUSY;
            BUSY: if (DMemAck || timeout) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Reset gates Stall so a held mem op cannot stall the pipe during reset.
    assign Stall      = ~Reset & (busy ? ~DMemAck : start);
    assign DMemReq    = busy;
    assign DMemWe     = busy & we_q;
    assign DMemAddr   = {addr_q[31:2], 2'b00};
    assign DMemByteEn = busy ? byte_en : 4'b0000;
    assign DMemWData  = busy ? wdata : 32'h0;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            addr_q     <= '0;
            sdata_q    <= '0;
            size_q     <= SZ_BYTE;
            signed_q   <= 1'b0;
            regwrite_q <= 1'b0;
            we_q       <= 1'b0;
            dest_q     <= '0;
        end else if (start) begin
            addr_q     <= ALUResult_In;
            sdata_q    <= StoreData_In;
            size_q     <= mem_size_t'(MemSize_In);
            signed_q   <= LoadSigned_In;
            regwrite_q <= RegWrite_In;
            we_q       <= MemWrite_In;
            dest_q     <= RegDest_In;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q       <= IDLE;
            ALUResult_Out <= '0;
            ReadData_Out  <= '0;
            RegDest_Out   <= '0;
            RegWrite_Out  <= 1'b0;
            MemToReg_Out  <= 1'b0;
            AddrError     <= 1'b0;
            BusError      <= 1'b0;
        end else begin
            state_q   <= state_d;
            AddrError <= 1'b0;
            BusError  <= 1'b0;
            if (!busy) begin
                ALUResult_Out <= ALUResult_In;
                RegDest_Out   <= RegDest_In;
                RegWrite_Out  <= RegWrite_In & ~mem_op;
                MemToReg_Out  <= 1'b0;
                AddrError     <= mem_op & misaligned;
            end else if (DMemAck) begin
                ALUResult_Out <= addr_q;
                RegDest_Out   <= dest_q;
                RegWrite_Out  <= regwrite_q & ~we_q;
                MemToReg_Out  <= ~we_q;
                if (!we_q) ReadData_Out <= load_data;
            end else begin
                RegWrite_Out <= 1'b0;
                MemToReg_Out <= 1'b0;
                BusError     <= timeout;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage (timeout case built with MEM_TIMEOUT_EN).
module tb_mem_access_stage;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        MemRead_In, MemWrite_In, LoadSigned_In, RegWrite_In;
    logic [1:0]  MemSize_In;
    logic [4:0]  RegDest_In;
    logic [31:0] ALUResult_In, StoreData_In;
    logic        DMemAck;
    logic [31:0] DMemRData;
    logic        DMemReq, DMemWe, Stall, RegWrite_Out, MemToReg_Out, AddrError, BusError;
    logic [31:0] DMemAddr, DMemWData, ALUResult_Out, ReadData_Out;
    logic [3:0]  DMemByteEn;
    logic [4:0]  RegDest_Out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 Clock = ~Clock;

    mem_access_stage #(
        .TIMEOUT_CYCLES (4),
        .CNT_W          (8)
    ) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .MemRead_In    (MemRead_In),
        .MemWrite_In   (MemWrite_In),
        .MemSize_In    (MemSize_In),
        .LoadSigned_In (LoadSigned_In),
        .RegWrite_In   (RegWrite_In),
        .RegDest_In    (RegDest_In),
        .ALUResult_In  (ALUResult_In),
        .StoreData_In  (StoreData_In),
        .DMemAck       (DMemAck),
        .DMemRData     (DMemRData),
        .DMemReq       (DMemReq),
        .DMemWe        (DMemWe),
        .DMemAddr      (DMemAddr),
        .DMemByteEn    (DMemByteEn),
        .DMemWData     (DMemWData),
        .Stall         (Stall),
        .ALUResult_Out (ALUResult_Out),
        .ReadData_Out  (ReadData_Out),
        .RegDest_Out   (RegDest_Out),
        .RegWrite_Out  (RegWrite_Out),
        .MemToReg_Out  (MemToReg_Out),
        .AddrError     (AddrError),
        .BusError      (BusError)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next active edge.
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic set_nop();
        MemRead_In    = 1'b0;
        MemWrite_In   = 1'b0;
        MemSize_In    = 2'b00;
        LoadSigned_In = 1'b0;
        RegWrite_In   = 1'b0;
        RegDest_In    = 5'd0;
        ALUResult_In  = 32'h0;
        StoreData_In  = 32'h0;
        DMemAck       = 1'b0;
        DMemRData     = 32'h0;
    endtask

    task automatic set_op(input logic rd, input logic wr, input logic [1:0] sz, input logic sgn,
                          input logic [4:0] dest, input logic [31:0] addr,
                          input logic [31:0] sdata);
        MemRead_In    = rd;
        MemWrite_In   = wr;
        MemSize_In    = sz;
        LoadSigned_In = sgn;
        RegWrite_In   = rd & ~wr;
        RegDest_In    = dest;
        ALUResult_In  = addr;
        StoreData_In  = sdata;
    endtask

    initial begin
        int stall_cycles;
        int busy_cycles;
        logic bus_err_seen;

        set_nop();
        Reset = 1'b1;
        step();
        step();
        check("rst_req", {31'h0, DMemReq}, 32'h0);
        check("rst_stall", {31'h0, Stall}, 32'h0);
        check("rst_regwrite", {31'h0, RegWrite_Out}, 32'h0);
        check("rst_alu", ALUResult_Out, 32'h0);
        check("rst_rdata", ReadData_Out, 32'h0);
        check("rst_byteen", {28'h0, DMemByteEn}, 32'h0);
        check("rst_errs", {30'h0, AddrError, BusError}, 32'h0);
        Reset = 1'b0;
        step();

        // Pass-through of a non-memory op.
        RegWrite_In  = 1'b1;
        RegDest_In   = 5'd5;
        ALUResult_In = 32'h1234;
        #1 check("pt_stall", {31'h0, Stall}, 32'h0);
        step();
        check("pt_regwrite", {31'h0, RegWrite_Out}, 32'h1);
        check("pt_dest", {27'h0, RegDest_Out}, 32'd5);
        check("pt_alu", ALUResult_Out, 32'h1234);
        check("pt_memtoreg", {31'h0, MemToReg_Out}, 32'h0);
        set_nop();

        // Ack while idle does nothing.
        DMemAck = 1'b1;
        #1 check("idle_ack_req", {31'h0, DMemReq}, 32'h0);
        step();
        check("idle_ack_state", {31'h0, DMemReq}, 32'h0);
        set_nop();

        // Signed byte load at 0x103, ack after three wait cycles.
        set_op(1'b1, 1'b0, 2'b00, 1'b1, 5'd7, 32'h103, 32'h0);
        stall_cycles = 0;
        for (int c = 0; c < 5; c++) begin
            DMemAck   = (c == 4);
            DMemRData = (c == 4) ? 32'h80FF_FF00 : 32'hAAAA_AAAA;
            #1;
            if (Stall) stall_cycles++;
            if (c == 0) check("lb_issue_req", {31'h0, DMemReq}, 32'h0);
            if (c == 1) begin
                check("lb_bubble", {30'h0, RegWrite_Out, MemToReg_Out}, 32'h0);
                check("lb_req", {31'h0, DMemReq}, 32'h1);
                check("lb_we", {31'h0, DMemWe}, 32'h0);
                check("lb_addr", DMemAddr, 32'h100);
                check("lb_byteen", {28'h0, DMemByteEn}, 32'b1000);
            end
            step();
        end
        set_nop();
        check("lb_stall_cycles", stall_cycles, 4);
        check("lb_rdata", ReadData_Out, 32'hFFFF_FF80);
        check("lb_regwrite", {31'h0, RegWrite_Out}, 32'h1);
        check("lb_dest", {27'h0, RegDest_Out}, 32'd7);
        check("lb_memtoreg", {31'h0, MemToReg_Out}, 32'h1);
        check("lb_done_req", {31'h0, DMemReq}, 32'h0);

        // Unsigned half load at 0x102, immediate ack.
        set_op(1'b1, 1'b0, 2'b01, 1'b0, 5'd3, 32'h102, 32'h0);
        step();
        DMemAck   = 1'b1;
        DMemRData = 32'h8001_7F7F;
        #1 check("lhu_stall_ack", {31'h0, Stall}, 32'h0);
        check("lhu_byteen", {28'h0, DMemByteEn}, 32'b1100);
        step();
        set_nop();
        check("lhu_rdata", ReadData_Out, 32'h0000_8001);

        // Half store at 0x202, immediate ack; read+write both set to exercise store priority.
        set_op(1'b1, 1'b1, 2'b01, 1'b0, 5'd9, 32'h202, 32'hDEAD_BEEF);
        RegWrite_In = 1'b1;
        step();
        DMemAck = 1'b1;
        #1;
        check("sh_req", {31'h0, DMemReq}, 32'h1);
        check("sh_we", {31'h0, DMemWe}, 32'h1);
        check("sh_addr", DMemAddr, 32'h200);
        check("sh_byteen", {28'h0, DMemByteEn}, 32'b1100);
        check("sh_wdata", DMemWData, 32'hBEEF_BEEF);
        step();
        set_nop();
        check("sh_regwrite", {31'h0, RegWrite_Out}, 32'h0);
        check("sh_memtoreg", {31'h0, MemToReg_Out}, 32'h0);
        check("sh_rdata_kept", ReadData_Out, 32'h0000_8001);

        // Byte store at offset 1.
        set_op(1'b0, 1'b1, 2'b00, 1'b0, 5'd1, 32'h301, 32'h1234_56A5);
        step();
        DMemAck = 1'b1;
        #1;
        check("sb_byteen", {28'h0, DMemByteEn}, 32'b0010);
        check("sb_wdata", DMemWData, 32'hA5A5_A5A5);
        step();
        set_nop();

        // Misaligned word load at 0x101.
        set_op(1'b1, 1'b0, 2'b10, 1'b0, 5'd4, 32'h101, 32'h0);
        #1 check("mis_stall", {31'h0, Stall}, 32'h0);
        step();
        set_nop();
        #1;
        check("mis_req", {31'h0, DMemReq}, 32'h0);
        check("mis_addrerr", {31'h0, AddrError}, 32'h1);
        check("mis_regwrite", {31'h0, RegWrite_Out}, 32'h0);
        step();
        check("mis_pulse_end", {31'h0, AddrError}, 32'h0);

        // Illegal size at an aligned address.
        set_op(1'b1, 1'b0, 2'b11, 1'b0, 5'd4, 32'h100, 32'h0);
        step();
        set_nop();
        check("ill_addrerr", {31'h0, AddrError}, 32'h1);
        check("ill_req", {31'h0, DMemReq}, 32'h0);

        // Reset in the second BUSY cycle abandons the access.
        set_op(1'b1, 1'b0, 2'b10, 1'b0, 5'd6, 32'h400, 32'h0);
        step();
        step();
        #1 Reset = 1'b1;
        #1;
        check("rstb_req", {31'h0, DMemReq}, 32'h0);
        check("rstb_stall", {31'h0, Stall}, 32'h0);
        check("rstb_alu", ALUResult_Out, 32'h0);
        check("rstb_regwrite", {31'h0, RegWrite_Out}, 32'h0);
        set_nop();
        step();
        Reset = 1'b0;
        step();
        check("rstb_idle_req", {31'h0, DMemReq}, 32'h0);
        check("rstb_idle_stall", {31'h0, Stall}, 32'h0);
        check("rstb_no_wb", {31'h0, RegWrite_Out}, 32'h0);

`ifdef MEM_TIMEOUT_EN
        // No ack: watchdog aborts after four BUSY cycles.
        set_op(1'b1, 1'b0, 2'b10, 1'b0, 5'd8, 32'h500, 32'h0);
        step();
        busy_cycles = 0;
        while (DMemReq && busy_cycles < 20) begin
            busy_cycles++;
            step();
        end
        set_nop();
        #1;
        check("to_busy_cycles", busy_cycles, 4);
        check("to_buserr", {31'h0, BusError}, 32'h1);
        check("to_stall", {31'h0, Stall}, 32'h0);
        check("to_regwrite", {31'h0, RegWrite_Out}, 32'h0);
        step();
        check("to_pulse_end", {31'h0, BusError}, 32'h0);
`else
        // Without the watchdog a BUSY access waits indefinitely.
        set_op(1'b1, 1'b0, 2'b10, 1'b0, 5'd8, 32'h500, 32'h0);
        step();
        bus_err_seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (BusError) bus_err_seen = 1'b1;
            step();
        end
        check("wait_buserr", {31'h0, bus_err_seen}, 32'h0);
        check("wait_req", {31'h0, DMemReq}, 32'h1);
        check("wait_stall", {31'h0, Stall}, 32'h1);
        DMemAck   = 1'b1;
        DMemRData = 32'h1122_3344;
        step();
        set_nop();
        check("wait_rdata", ReadData_Out, 32'h1122_3344);
        check("wait_dest", {27'h0, RegDest_Out}, 32'd8);
        busy_cycles = 0;
        check("wait_idle_req", {31'h0, DMemReq}, busy_cycles);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage directly downstream of the execute stage; consumes its ALUResult (effective address), FWMuxB_Out (store data), RegDest and RegWrite.
- Drives a req/ack data-memory port with variable wait states, aligns byte/half/word loads and stores, and stalls the upstream pipeline while an access is outstanding.
- Registers results toward write-back; its registered ALU and load values are what execute consumes as FWFromMEM and MEM_ReadData.

Parameters:
- TIMEOUT_CYCLES, 255, maximum BUSY cycles before abort (used only with MEM_TIMEOUT_EN).
- CNT_W, 8, watchdog counter width; must hold TIMEOUT_CYCLES.

Ports:
- Clock  in  1  pipeline clock, rising edge.
- Reset  in  1  asynchronous, active-high.
- MemRead_In  in  1  load op.
- MemWrite_In  in  1  store op.
- MemSize_In  in  2  00 byte, 01 half, 10 word, 11 illegal.
- LoadSigned_In  in  1  sign-extend the load.
- RegWrite_In  in  1  from execute.
- RegDest_In  in  5  from execute.
- ALUResult_In  in  32  result or effective address.
- StoreData_In  in  32  execute FWMuxB_Out.
- DMemAck  in  1  memory completes the access this cycle.
- DMemRData  in  32  read word; valid with DMemAck.
- DMemReq  out  1  access request.
- DMemWe  out  1  write strobe.
- DMemAddr  out  32  word address ({addr[31:2],2'b00}).
- DMemByteEn  out  4  lane enables.
- DMemWData  out  32  lane-replicated store data.
- Stall  out  1  freeze upstream stages.
- ALUResult_Out  out  32  registered ALUResult_In.
- ReadData_Out  out  32  registered aligned load data.
- RegDest_Out  out  5  registered.
- RegWrite_Out  out  1  registered; 0 for bubbles and faults.
- MemToReg_Out  out  1  registered MemRead.
- AddrError  out  1  one-cycle registered misalignment pulse.
- BusError  out  1  one-cycle registered timeout pulse (0 when feature is out).

Behaviour:
- Reset (async): FSM IDLE; all registered outputs 0; DMemReq/DMemWe/DMemByteEn 0; Stall 0. Reset during BUSY drops DMemReq immediately and abandons the access; no write-back occurs.
- FSM states are IDLE and BUSY.
- IDLE, no mem op: inputs register to outputs next edge; latency 1; Stall 0.
- IDLE, mem op, aligned: Stall=1 combinationally. Address, size, sign, store data and dest are latched. Next state BUSY. Outputs take a bubble (RegWrite_Out=0, MemToReg_Out=0).
- IDLE, mem op, misaligned: no access. Misaligned means half with addr[0]=1, word with addr[1:0]!=0, or size 11. Next edge AddrError=1 and RegWrite_Out=0; Stall 0.
- BUSY: DMemReq=1 with address/We/ByteEn/WData stable from latched values. Stall = ~DMemAck. On DMemAck: the formatted load registers into ReadData_Out, latched dest/RegWrite register out, next state IDLE.
- Minimum mem-op latency is 2 cycles (ack in the first BUSY cycle). A store's RegWrite_Out is forced to 0.
- Simultaneous MemRead_In and MemWrite_In: the store takes precedence.
- Little-endian lanes; off = addr[1:0].
- Byte enables: byte 0001<<off; half 0011<<off; word 1111.
- Store data: byte {4{d[7:0]}}; half {2{d[15:0]}}; word d.
- Load: shift DMemRData right by 8*off, then extend from 8/16 bits; signed per LoadSigned.
- DMemAck while IDLE is ignored.

Optional Feature:
- MEM_TIMEOUT_EN defined: a CNT_W-bit counter clears on BUSY entry and increments each BUSY cycle without ack. On reaching TIMEOUT_CYCLES: return to IDLE, drop DMemReq, release Stall, pulse BusError for one cycle, RegWrite_Out=0.
- Undefined: no counter; BUSY waits indefinitely; BusError tied 0.

Decomposition:
- Shared package holds: mem_size_t (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILLEGAL), the mem-stage state enum (IDLE, BUSY), and the lane-offset constants.
- One combinational sub-module, mem_lane_align, computes byte enables, store replication, load extraction/extension and the misalign flag; the FSM and registers stay in the top.

Test Plan:
- Pass-through: RegWrite=1, RegDest=5, ALUResult=0x1234 with no mem op -> next cycle RegWrite_Out=1, RegDest_Out=5, ALUResult_Out=0x1234, Stall never high.
- Signed byte load, addr 0x103, ack after 3 wait cycles, RData 0x80FF_FF00 -> DMemAddr 0x100, ByteEn 1000, Stall high 4 cycles, ReadData_Out 0xFFFF_FF80.
- Half store, addr 0x202, data 0xDEAD_BEEF, ack immediate -> DMemWe=1, ByteEn 1100, WData 0xBEEF_BEEF, RegWrite_Out=0.
- Word load at 0x101 -> no DMemReq, AddrError pulse 1 cycle, RegWrite_Out=0, Stall 0.
- Reset asserted in the 2nd BUSY cycle -> DMemReq, Stall and all outputs 0 immediately; IDLE after release.
- MEM_TIMEOUT_EN with TIMEOUT_CYCLES=4, no ack -> BusError pulse after 4 BUSY cycles, Stall released, RegWrite_Out=0.
